// File: rtl/cpu_defs_pkg.sv
// ============================================================================
// Module : cpu_defs_pkg
// Brief  : ISA opcodes, ALU functions, control words, FSM states and the
//          decoded control bundle shared by control_unit and the ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_defs_pkg;

   localparam logic [3:0] c_op_nop       = 4'h0;
   localparam logic [3:0] c_op_arith_2op = 4'h1;
   localparam logic [3:0] c_op_arith_1op = 4'h2;
   localparam logic [3:0] c_op_movi      = 4'h3;
   localparam logic [3:0] c_op_addi      = 4'h4;
   localparam logic [3:0] c_op_subi      = 4'h5;
   localparam logic [3:0] c_op_load      = 4'h6;
   localparam logic [3:0] c_op_stor      = 4'h7;
   localparam logic [3:0] c_op_beq       = 4'h8;
   localparam logic [3:0] c_op_bge       = 4'h9;
   localparam logic [3:0] c_op_ble       = 4'hA;
   localparam logic [3:0] c_op_bc        = 4'hB;
   localparam logic [3:0] c_op_j         = 4'hC;
   localparam logic [3:0] c_op_ill0      = 4'hD;
   localparam logic [3:0] c_op_ill1      = 4'hE;
   localparam logic [3:0] c_op_ctrl      = 4'hF;

   // Two-operand ALU functions
   localparam logic [2:0] c_func_add = 3'd0;
   localparam logic [2:0] c_func_adc = 3'd1;
   localparam logic [2:0] c_func_sub = 3'd2;
   localparam logic [2:0] c_func_sbb = 3'd3;
   localparam logic [2:0] c_func_and = 3'd4;
   localparam logic [2:0] c_func_or  = 3'd5;
   localparam logic [2:0] c_func_xor = 3'd6;
   localparam logic [2:0] c_func_cmp = 3'd7;

   // One-operand ALU functions
   localparam logic [2:0] c_f1_not = 3'd0;
   localparam logic [2:0] c_f1_shl = 3'd1;
   localparam logic [2:0] c_f1_shr = 3'd2;
   localparam logic [2:0] c_f1_inc = 3'd3;
   localparam logic [2:0] c_f1_dec = 3'd4;

   localparam logic [15:0] c_cw_stc   = 16'hF001;
   localparam logic [15:0] c_cw_stb   = 16'hF002;
   localparam logic [15:0] c_cw_reset = 16'hFAAA;
   localparam logic [15:0] c_cw_halt  = 16'hFFFF;

   localparam logic [1:0] c_wb_alu = 2'd0;
   localparam logic [1:0] c_wb_mem = 2'd1;
   localparam logic [1:0] c_wb_imm = 2'd2;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALTED    = 3'd5
   } state_t;

   typedef struct packed {
      logic       arith_1op;
      logic       arith_2op;
      logic       addi;
      logic       subi;
      logic       load_or_store;
      logic [2:0] alu_func;
      logic [5:0] immediate;
      logic [2:0] reg1_addr;
      logic [2:0] reg2_addr;
      logic [2:0] reg_waddr;
      logic [1:0] wb_sel;
      logic       is_load;
      logic       is_stor;
      logic       is_branch;
      logic [3:0] branch_type;
      logic       writes_reg;
      logic       is_stc;
      logic       is_stb;
      logic       is_soft_reset;
      logic       is_halt;
      logic       is_illegal;
   } ctrl_t;

   function automatic logic is_branch_op(input logic [3:0] opcode);
      return (opcode >= c_op_beq) && (opcode <= c_op_j);
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decoder.sv
// ============================================================================
// Module : instr_decoder
// Brief  : Combinational mapping of a 16-bit instruction word to a ctrl_t.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_decoder
   import cpu_defs_pkg::*;
(
   input  logic [15:0] i_instr,
   output ctrl_t       o_ctrl
);

   logic [3:0] w_opcode;

   assign w_opcode = i_instr[15:12];

   always_comb begin
      o_ctrl           = '0;
      // Field extraction is opcode-independent; the strobes qualify it
      o_ctrl.alu_func  = i_instr[2:0];
      o_ctrl.immediate = i_instr[5:0];
      o_ctrl.reg1_addr = i_instr[8:6];
      o_ctrl.reg2_addr = i_instr[5:3];
      o_ctrl.reg_waddr = i_instr[11:9];
      o_ctrl.wb_sel    = c_wb_alu;

      if (is_branch_op(w_opcode)) begin
         o_ctrl.is_branch   = 1'b1;
         o_ctrl.branch_type = w_opcode;
      end

      case (w_opcode)
         c_op_arith_1op: begin
            o_ctrl.arith_1op  = 1'b1;
            o_ctrl.writes_reg = 1'b1;
         end
         c_op_arith_2op: begin
            o_ctrl.arith_2op  = 1'b1;
            o_ctrl.writes_reg = 1'b1;
         end
         c_op_movi: begin
            o_ctrl.writes_reg = 1'b1;
            o_ctrl.wb_sel     = c_wb_imm;
         end
         c_op_addi: begin
            o_ctrl.addi       = 1'b1;
            o_ctrl.writes_reg = 1'b1;
         end
         c_op_subi: begin
            o_ctrl.subi       = 1'b1;
            o_ctrl.writes_reg = 1'b1;
         end
         c_op_load: begin
            o_ctrl.load_or_store = 1'b1;
            o_ctrl.is_load       = 1'b1;
            o_ctrl.writes_reg    = 1'b1;
            o_ctrl.wb_sel        = c_wb_mem;
         end
         c_op_stor: begin
            // Store data register lives in the destination field
            o_ctrl.load_or_store = 1'b1;
            o_ctrl.is_stor       = 1'b1;
            o_ctrl.reg2_addr     = i_instr[11:9];
         end
         c_op_ill0, c_op_ill1: begin
            o_ctrl.is_illegal = 1'b1;
         end
         c_op_ctrl: begin
            case (i_instr)
               c_cw_stc:   o_ctrl.is_stc        = 1'b1;
               c_cw_stb:   o_ctrl.is_stb        = 1'b1;
               c_cw_reset: o_ctrl.is_soft_reset = 1'b1;
               c_cw_halt:  o_ctrl.is_halt       = 1'b1;
               default:    ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module : control_unit
// Brief  : Fetch/decode/execute sequencer with carry/borrow flag ownership.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module control_unit
   import cpu_defs_pkg::*;
(
   input  logic        clk_pi,
   input  logic        reset_pi,
   output logic        instr_req_po,
   input  logic        instr_valid_pi,
   input  logic [15:0] instr_pi,
   output logic        arith_1op_po,
   output logic        arith_2op_po,
   output logic        addi_po,
   output logic        subi_po,
   output logic        load_or_store_po,
   output logic [2:0]  alu_func_po,
   output logic [5:0]  immediate_po,
   output logic        stc_cmd_po,
   output logic        stb_cmd_po,
   output logic        carry_flag_po,
   output logic        borrow_flag_po,
   input  logic        alu_carry_pi,
   input  logic        alu_borrow_pi,
   output logic [2:0]  reg1_addr_po,
   output logic [2:0]  reg2_addr_po,
   output logic        reg_we_po,
   output logic [2:0]  reg_waddr_po,
   output logic [1:0]  wb_sel_po,
   output logic        mem_req_po,
   output logic        mem_we_po,
   input  logic        mem_ack_pi,
   output logic        branch_po,
   output logic [3:0]  branch_type_po,
   output logic        pc_advance_po,
   output logic        soft_reset_po,
   output logic        halted_po,
   output logic        illegal_po
);

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_instr;
   ctrl_t       r_ctrl;
   ctrl_t       w_dec;
   logic        r_instr_req;
   logic        r_carry;
   logic        r_borrow;
   logic        r_illegal;

   logic        w_pc_advance;
   logic        w_branch;
   logic        w_stc;
   logic        w_stb;
   logic        w_soft_reset;
   logic        w_mem_req;
   logic        w_mem_we;
   logic        w_reg_we;
   logic        w_halted;

   instr_decoder u_decoder (
      .i_instr (r_instr),
      .o_ctrl  (w_dec)
   );

   always_ff @(posedge clk_pi) begin
      if (reset_pi) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_pc_advance = 1'b0;
      w_branch     = 1'b0;
      w_stc        = 1'b0;
      w_stb        = 1'b0;
      w_soft_reset = 1'b0;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_reg_we     = 1'b0;
      w_halted     = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (instr_valid_pi) w_next_state = ST_DECODE;
         end
         ST_DECODE: begin
            w_next_state = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            w_pc_advance = !r_ctrl.is_branch;
            w_branch     = r_ctrl.is_branch;
            w_stc        = r_ctrl.is_stc;
            w_stb        = r_ctrl.is_stb;
            w_soft_reset = r_ctrl.is_soft_reset;
            if (r_ctrl.is_halt)            w_next_state = ST_HALTED;
            else if (r_ctrl.load_or_store) w_next_state = ST_MEM;
            else if (r_ctrl.writes_reg)    w_next_state = ST_WRITEBACK;
            else                           w_next_state = ST_FETCH;
         end
         ST_MEM: begin
            w_mem_req = 1'b1;
            w_mem_we  = r_ctrl.is_stor;
            if (mem_ack_pi) begin
               w_next_state = r_ctrl.is_load ? ST_WRITEBACK : ST_FETCH;
            end
         end
         ST_WRITEBACK: begin
            w_reg_we     = 1'b1;
            w_next_state = ST_FETCH;
         end
         ST_HALTED: begin
            w_halted = 1'b1;
         end
         default: begin
            w_next_state = ST_FETCH;
         end
      endcase
   end

   // Request is registered so it stays low for the whole reset window
   always_ff @(posedge clk_pi) begin
      if (reset_pi) begin
         r_instr     <= '0;
         r_ctrl      <= '0;
         r_instr_req <= 1'b0;
         r_carry     <= 1'b0;
         r_borrow    <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_instr_req <= (w_next_state == ST_FETCH);
         if (r_state == ST_FETCH && instr_valid_pi) r_instr <= instr_pi;

         if (w_next_state == ST_FETCH || w_next_state == ST_HALTED) begin
            r_ctrl <= '0;
         end else if (r_state == ST_DECODE) begin
            r_ctrl <= w_dec;
         end

         if (r_state == ST_EXECUTE) begin
            if (r_ctrl.is_soft_reset) begin
               r_carry  <= 1'b0;
               r_borrow <= 1'b0;
            end else begin
               r_carry  <= alu_carry_pi;
               r_borrow <= alu_borrow_pi;
            end
            if (r_ctrl.is_illegal) r_illegal <= 1'b1;
         end
      end
   end

   assign instr_req_po     = r_instr_req;
   assign arith_1op_po     = r_ctrl.arith_1op;
   assign arith_2op_po     = r_ctrl.arith_2op;
   assign addi_po          = r_ctrl.addi;
   assign subi_po          = r_ctrl.subi;
   assign load_or_store_po = r_ctrl.load_or_store;
   assign alu_func_po      = r_ctrl.alu_func;
   assign immediate_po     = r_ctrl.immediate;
   assign reg1_addr_po     = r_ctrl.reg1_addr;
   assign reg2_addr_po     = r_ctrl.reg2_addr;
   assign reg_waddr_po     = r_ctrl.reg_waddr;
   assign wb_sel_po        = r_ctrl.wb_sel;
   assign branch_type_po   = r_ctrl.branch_type;
   assign carry_flag_po    = r_carry;
   assign borrow_flag_po   = r_borrow;
   assign illegal_po       = r_illegal;
   assign pc_advance_po    = w_pc_advance;
   assign branch_po        = w_branch;
   assign stc_cmd_po       = w_stc;
   assign stb_cmd_po       = w_stb;
   assign soft_reset_po    = w_soft_reset;
   assign mem_req_po       = w_mem_req;
   assign mem_we_po        = w_mem_we;
   assign reg_we_po        = w_reg_we;
   assign halted_po        = w_halted;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module : tb_control_unit
// Brief  : Scoreboard bench for control_unit with directed instruction words.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_control_unit;

   logic        clk_pi = 1'b0;
   logic        reset_pi = 1'b1;
   logic        instr_req_po;
   logic        instr_valid_pi = 1'b0;
   logic [15:0] instr_pi = '0;
   logic        arith_1op_po, arith_2op_po, addi_po, subi_po, load_or_store_po;
   logic [2:0]  alu_func_po;
   logic [5:0]  immediate_po;
   logic        stc_cmd_po, stb_cmd_po;
   logic        carry_flag_po, borrow_flag_po;
   logic        alu_carry_pi = 1'b0;
   logic        alu_borrow_pi = 1'b0;
   logic [2:0]  reg1_addr_po, reg2_addr_po;
   logic        reg_we_po;
   logic [2:0]  reg_waddr_po;
   logic [1:0]  wb_sel_po;
   logic        mem_req_po, mem_we_po;
   logic        mem_ack_pi = 1'b0;
   logic        branch_po;
   logic [3:0]  branch_type_po;
   logic        pc_advance_po, soft_reset_po, halted_po, illegal_po;

   int n_cmp = 0;
   int n_err = 0;

   logic [27:0] exec_q[$];
   logic [4:0]  wb_q[$];
   logic [27:0] w_obs_exec;
   logic [4:0]  w_obs_wb;

   control_unit dut (
      .clk_pi           (clk_pi),
      .reset_pi         (reset_pi),
      .instr_req_po     (instr_req_po),
      .instr_valid_pi   (instr_valid_pi),
      .instr_pi         (instr_pi),
      .arith_1op_po     (arith_1op_po),
      .arith_2op_po     (arith_2op_po),
      .addi_po          (addi_po),
      .subi_po          (subi_po),
      .load_or_store_po (load_or_store_po),
      .alu_func_po      (alu_func_po),
      .immediate_po     (immediate_po),
      .stc_cmd_po       (stc_cmd_po),
      .stb_cmd_po       (stb_cmd_po),
      .carry_flag_po    (carry_flag_po),
      .borrow_flag_po   (borrow_flag_po),
      .alu_carry_pi     (alu_carry_pi),
      .alu_borrow_pi    (alu_borrow_pi),
      .reg1_addr_po     (reg1_addr_po),
      .reg2_addr_po     (reg2_addr_po),
      .reg_we_po        (reg_we_po),
      .reg_waddr_po     (reg_waddr_po),
      .wb_sel_po        (wb_sel_po),
      .mem_req_po       (mem_req_po),
      .mem_we_po        (mem_we_po),
      .mem_ack_pi       (mem_ack_pi),
      .branch_po        (branch_po),
      .branch_type_po   (branch_type_po),
      .pc_advance_po    (pc_advance_po),
      .soft_reset_po    (soft_reset_po),
      .halted_po        (halted_po),
      .illegal_po       (illegal_po)
   );

   always #5 clk_pi = ~clk_pi;

   assign w_obs_exec = {branch_po, branch_type_po, stc_cmd_po, stb_cmd_po, soft_reset_po,
                        arith_1op_po, arith_2op_po, addi_po, subi_po, load_or_store_po,
                        alu_func_po, immediate_po, reg1_addr_po, reg2_addr_po};
   assign w_obs_wb   = {reg_waddr_po, wb_sel_po};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected execute bundle: {branch, type, {stc,stb,srst}, {a1,a2,addi,subi,ls}, func, imm, r1, r2}
   function automatic logic [27:0] ex(input logic br, input logic [3:0] bt, input logic [2:0] cmd,
                                      input logic [4:0] cls, input logic [2:0] func,
                                      input logic [5:0] imm, input logic [2:0] r1, input logic [2:0] r2);
      return {br, bt, cmd, cls, func, imm, r1, r2};
   endfunction

   // Monitor: every execute cycle and every writeback is scored against the queues
   always @(negedge clk_pi) begin
      if (pc_advance_po || branch_po) begin
         if (exec_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL exec_unexpected: got 0x%0h, expected no execute", w_obs_exec);
         end else begin
            check("exec_bundle", 32'(w_obs_exec), 32'(exec_q.pop_front()));
         end
      end
      if (reg_we_po) begin
         if (wb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL wb_unexpected: got 0x%0h, expected no writeback", w_obs_wb);
         end else begin
            check("wb_waddr_sel", 32'(w_obs_wb), 32'(wb_q.pop_front()));
         end
      end
   end

   task automatic wait_req(input string name);
      int i;
      i = 0;
      while (!instr_req_po && i < 60) begin
         @(negedge clk_pi);
         i++;
      end
      check({name, "_req"}, 32'(instr_req_po), 32'd1);
   endtask

   // Returns at the negedge of the DECODE cycle
   task automatic fetch(input logic [15:0] word);
      wait_req("fetch");
      instr_valid_pi = 1'b1;
      instr_pi       = word;
      @(negedge clk_pi);
      instr_valid_pi = 1'b0;
      instr_pi       = 16'h0000;
   endtask

   task automatic do_mem(input string name, input int n, input logic we);
      int i;
      int cnt;
      i = 0;
      cnt = 0;
      while (!mem_req_po && i < 20) begin
         @(negedge clk_pi);
         i++;
      end
      check({name, "_we"}, 32'(mem_we_po), 32'(we));
      while (mem_req_po && cnt < 20) begin
         cnt++;
         if (cnt == n) mem_ack_pi = 1'b1;
         @(negedge clk_pi);
         mem_ack_pi = 1'b0;
      end
      check({name, "_req_cycles"}, 32'(cnt), 32'(n));
   endtask

   initial begin
      int bad;
      repeat (3) @(negedge clk_pi);
      check("reset_outputs",
            32'({instr_req_po, halted_po, illegal_po, carry_flag_po, borrow_flag_po,
                 reg_we_po, mem_req_po, pc_advance_po, arith_2op_po, wb_sel_po}), 32'd0);
      reset_pi = 1'b0;
      @(negedge clk_pi);
      check("req_after_reset", 32'(instr_req_po), 32'd1);

      // ADD r1,r2,r3 with ALU carry out
      exec_q.push_back(ex(1'b0, 4'h0, 3'b000, 5'b01000, 3'd0, 6'd24, 3'd2, 3'd3));
      wb_q.push_back({3'd1, 2'd0});
      alu_carry_pi = 1'b1;
      fetch(16'h1298);
      @(negedge clk_pi);
      check("add_pc_advance", 32'(pc_advance_po), 32'd1);
      @(negedge clk_pi);
      check("add_wb_cycle4", 32'(reg_we_po), 32'd1);
      @(negedge clk_pi);
      check("add_carry_flag", 32'({carry_flag_po, borrow_flag_po}), 32'b10);
      alu_carry_pi = 1'b0;

      // ADDI r1,r1,5 then STC
      exec_q.push_back(ex(1'b0, 4'h0, 3'b000, 5'b00100, 3'd5, 6'd5, 3'd1, 3'd0));
      wb_q.push_back({3'd1, 2'd0});
      fetch(16'h4245);
      exec_q.push_back(ex(1'b0, 4'h0, 3'b100, 5'b00000, 3'd1, 6'd1, 3'd0, 3'd0));
      fetch(16'hF001);
      @(negedge clk_pi);
      check("stc_pulse", 32'(stc_cmd_po), 32'd1);
      @(negedge clk_pi);
      check("stc_single_no_wb", 32'({stc_cmd_po, reg_we_po}), 32'd0);

      // LOAD r4,[r2+3] with 3-cycle memory
      exec_q.push_back(ex(1'b0, 4'h0, 3'b000, 5'b00001, 3'd3, 6'd3, 3'd2, 3'd0));
      wb_q.push_back({3'd4, 2'd1});
      fetch(16'h6883);
      do_mem("load", 3, 1'b0);

      // STOR: reg2 from [11:9], write strobe, no writeback
      exec_q.push_back(ex(1'b0, 4'h0, 3'b000, 5'b00001, 3'd3, 6'd3, 3'd2, 3'd4));
      fetch(16'h7883);
      do_mem("stor", 1, 1'b1);

      // BEQ: branch strobe, no pc advance
      exec_q.push_back(ex(1'b1, 4'h8, 3'b000, 5'b00000, 3'd5, 6'd5, 3'd0, 3'd0));
      fetch(16'h8005);
      @(negedge clk_pi);
      check("beq_no_pc_adv", 32'(pc_advance_po), 32'd0);

      // MOVI writes back the immediate
      exec_q.push_back(ex(1'b0, 4'h0, 3'b000, 5'b00000, 3'd3, 6'd35, 3'd4, 3'd4));
      wb_q.push_back({3'd0, 2'd2});
      fetch(16'h3123);

      // Illegal opcode behaves as NOP and sticks
      exec_q.push_back(ex(1'b0, 4'h0, 3'b000, 5'b00000, 3'd0, 6'd0, 3'd0, 3'd0));
      fetch(16'hD000);
      wait_req("illegal");
      check("illegal_sticky", 32'(illegal_po), 32'd1);

      // Set both flags, then RESET command clears them despite ALU outputs
      alu_carry_pi  = 1'b1;
      alu_borrow_pi = 1'b1;
      exec_q.push_back(ex(1'b0, 4'h0, 3'b000, 5'b00000, 3'd1, 6'd1, 3'd0, 3'd0));
      wb_q.push_back({3'd7, 2'd2});
      fetch(16'h3E01);
      wait_req("flags");
      check("flags_set", 32'({carry_flag_po, borrow_flag_po}), 32'b11);
      exec_q.push_back(ex(1'b0, 4'h0, 3'b001, 5'b00000, 3'd2, 6'd42, 3'd2, 3'd5));
      fetch(16'hFAAA);
      @(negedge clk_pi);
      @(negedge clk_pi);
      check("soft_reset_flags", 32'({carry_flag_po, borrow_flag_po, instr_req_po}), 32'b001);
      check("illegal_kept", 32'(illegal_po), 32'd1);
      alu_carry_pi  = 1'b0;
      alu_borrow_pi = 1'b0;

      // Reset during MEM; ack arriving afterwards is ignored
      exec_q.push_back(ex(1'b0, 4'h0, 3'b000, 5'b00001, 3'd3, 6'd3, 3'd2, 3'd0));
      fetch(16'h6883);
      bad = 0;
      while (!mem_req_po && bad < 20) begin
         @(negedge clk_pi);
         bad++;
      end
      check("rst_mem_entered", 32'(mem_req_po), 32'd1);
      reset_pi = 1'b1;
      @(negedge clk_pi);
      reset_pi   = 1'b0;
      mem_ack_pi = 1'b1;
      check("rst_mem_req_drop", 32'({mem_req_po, instr_req_po}), 32'd0);
      @(negedge clk_pi);
      mem_ack_pi = 1'b0;
      check("rst_mem_state", 32'({instr_req_po, reg_we_po, illegal_po}), 32'b100);

      // HALT: stays halted, no fetch requests, valid ignored
      exec_q.push_back(ex(1'b0, 4'h0, 3'b000, 5'b00000, 3'd7, 6'd63, 3'd7, 3'd7));
      fetch(16'hFFFF);
      @(negedge clk_pi);
      @(negedge clk_pi);
      check("halted", 32'(halted_po), 32'd1);
      bad = 0;
      instr_valid_pi = 1'b1;
      instr_pi       = 16'h1298;
      for (int k = 0; k < 20; k++) begin
         if (instr_req_po !== 1'b0 || halted_po !== 1'b1) bad++;
         @(negedge clk_pi);
      end
      instr_valid_pi = 1'b0;
      check("halt_hold_20", 32'(bad), 32'd0);

      check("exec_q_drained", 32'(exec_q.size()), 32'd0);
      check("wb_q_drained", 32'(wb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
